// File: rtl/ddp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddp_pkg
// Brief    : Shared encodings and bar colour table for the display pipe.
// Revision : 1.0 - initial release
// ============================================================================
package ddp_pkg;

    typedef enum logic [1:0] {
        MODE_VRAM    = 2'd0,
        MODE_WHITE   = 2'd1,
        MODE_BARS    = 2'd2,
        MODE_CHECKER = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        SCALE_X1 = 2'd0,
        SCALE_X2 = 2'd1,
        SCALE_X4 = 2'd2,
        SCALE_X8 = 2'd3
    } scale_e;

    localparam logic [11:0] c_white = 12'hFFF;
    localparam logic [11:0] c_black = 12'h000;

    // Entry 0 is the leftmost bar.
    localparam logic [7:0][11:0] c_bar_colours = {
        12'h000, 12'h00F, 12'hF00, 12'hF0F,
        12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
    };

    // Last sub-pixel index (F-1) for a given upscale factor.
    function automatic logic [2:0] sub_max(input logic [1:0] s);
        logic [2:0] m;
        m = 3'd0;
        case (scale_e'(s))
            SCALE_X1: m = 3'd0;
            SCALE_X2: m = 3'd1;
            SCALE_X4: m = 3'd3;
            SCALE_X8: m = 3'd7;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : display_pipe_if
// Brief    : VRAM read port between the display pipe and the video memory.
// Revision : 1.0 - initial release
// ============================================================================
interface display_pipe_if #(
    parameter int DW = 15
);
    logic [DW-1:0] raddr;
    logic [11:0]   rdata;

    modport master (output raddr, input rdata);
    modport slave  (input raddr, output rdata);
endinterface
`default_nettype wire

// File: rtl/ddp_delay.sv
`default_nettype none
// ============================================================================
// Module   : ddp_delay
// Brief    : Parametrised shift-register delay line, asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module ddp_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  wire logic             pclk,
    input  wire logic             rstn,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            r_pipe <= '{default: '0};
        end else begin
            r_pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign dout = r_pipe[DEPTH-1];
endmodule
`default_nettype wire

// File: rtl/display_pipe.sv
`default_nettype none
// ============================================================================
// Module   : display_pipe
// Brief    : Upscaling VRAM fetch and test-pattern generator with RGB444 out.
// Revision : 1.0 - initial release
// ============================================================================
module display_pipe
    import ddp_pkg::*;
#(
    parameter int DW     = 15,
    parameter int H_LEN  = 200,
    parameter int V_LEN  = 150,
    parameter int RD_LAT = 1
) (
    input  wire logic       pclk,
    input  wire logic       rstn,
    input  wire logic       hen,
    input  wire logic       ven,
    input  wire logic [1:0] scale,
    input  wire logic [1:0] mode,
    display_pipe_if.master  vram,
    output logic      [3:0] red,
    output logic      [3:0] green,
    output logic      [3:0] blue,
    output logic            de_out,
    output logic            frame_start
);
    localparam int c_xw = $clog2(H_LEN + 1);
    localparam int c_yw = $clog2(V_LEN + 1);
    localparam int c_pw = 1 + 2 + c_xw + 1;
    localparam int c_bar_thr [7] = '{H_LEN*1/8, H_LEN*2/8, H_LEN*3/8, H_LEN*4/8,
                                     H_LEN*5/8, H_LEN*6/8, H_LEN*7/8};

    logic [1:0]    r_scale;
    logic [2:0]    r_x_sub, r_y_sub;
    logic [c_xw-1:0] r_x_idx;
    logic [c_yw-1:0] r_y_idx;
    logic [DW-1:0] r_line_base;
    logic          r_hen_d, r_ven_d, r_frame_start;
    logic [11:0]   r_rgb;

    logic [2:0]    w_sub_max;
    logic          w_in_bounds, w_active;
    logic [c_pw-1:0] w_pipe_in, w_pipe_out;
    logic          w_d_active, w_d_y3;
    logic [1:0]    w_d_mode;
    logic [c_xw-1:0] w_d_x;
    logic [2:0]    w_bar_idx;
    logic [11:0]   w_colour;

    assign w_sub_max = sub_max(r_scale);

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            r_scale       <= '0;
            r_x_sub       <= '0;
            r_x_idx       <= '0;
            r_y_sub       <= '0;
            r_y_idx       <= '0;
            r_line_base   <= '0;
            r_hen_d       <= 1'b0;
            r_ven_d       <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_scale       <= ven ? r_scale : scale;
            r_hen_d       <= hen;
            r_ven_d       <= ven;
            r_frame_start <= ven & ~r_ven_d;

            // >= rather than == keeps the counter sane if scale moved under it.
            if (!hen) begin
                r_x_sub <= '0;
                r_x_idx <= '0;
            end else if (r_x_sub >= w_sub_max) begin
                r_x_sub <= '0;
                if (r_x_idx < c_xw'(H_LEN)) r_x_idx <= r_x_idx + c_xw'(1);
            end else begin
                r_x_sub <= r_x_sub + 3'd1;
            end

            if (!ven) begin
                r_y_sub     <= '0;
                r_y_idx     <= '0;
                r_line_base <= '0;
            end else if (r_hen_d && !hen) begin
                if (r_y_sub >= w_sub_max) begin
                    r_y_sub     <= '0;
                    r_line_base <= r_line_base + DW'(H_LEN);
                    if (r_y_idx < c_yw'(V_LEN)) r_y_idx <= r_y_idx + c_yw'(1);
                end else begin
                    r_y_sub <= r_y_sub + 3'd1;
                end
            end
        end
    end

    assign w_in_bounds = (r_x_idx < c_xw'(H_LEN)) && (r_y_idx < c_yw'(V_LEN));
    assign vram.raddr  = w_in_bounds ? (r_line_base + DW'(r_x_idx)) : '0;
    assign w_active    = hen & ven & w_in_bounds;

    // Only row bit 3 is consumed downstream (checkerboard parity).
    assign w_pipe_in = {w_active, mode, r_x_idx, r_y_idx[3]};

    ddp_delay #(.WIDTH(c_pw), .DEPTH(RD_LAT)) u_pix_delay (
        .pclk (pclk),
        .rstn (rstn),
        .din  (w_pipe_in),
        .dout (w_pipe_out)
    );

    ddp_delay #(.WIDTH(1), .DEPTH(RD_LAT + 1)) u_de_delay (
        .pclk (pclk),
        .rstn (rstn),
        .din  (hen & ven),
        .dout (de_out)
    );

    assign {w_d_active, w_d_mode, w_d_x, w_d_y3} = w_pipe_out;

    always_comb begin
        w_bar_idx = 3'd0;
        for (int k = 0; k < 7; k++) begin
            if (int'(w_d_x) >= c_bar_thr[k]) w_bar_idx = 3'(k + 1);
        end

        w_colour = c_black;
        case (mode_e'(w_d_mode))
            MODE_VRAM:    w_colour = vram.rdata;
            MODE_WHITE:   w_colour = c_white;
            MODE_BARS:    w_colour = c_bar_colours[w_bar_idx];
            MODE_CHECKER: w_colour = (w_d_x[3] ^ w_d_y3) ? c_white : c_black;
        endcase
    end

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) r_rgb <= '0;
        else       r_rgb <= w_d_active ? w_colour : c_black;
    end

    assign {red, green, blue} = r_rgb;
    assign frame_start        = r_frame_start;
endmodule
`default_nettype wire

// File: tb/tb_display_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_pipe
// Brief    : Directed bench for display_pipe at read latencies 1 and 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_pipe;
    localparam int LOGN = 32768;

    logic       pclk, rstn, hen, ven;
    logic [1:0] scale, mode;
    logic [3:0] red1, green1, blue1, red3, green3, blue3;
    logic       de1, fs1, de3, fs3;

    display_pipe_if #(.DW(15)) vif1 ();
    display_pipe_if #(.DW(15)) vif3 ();

    display_pipe #(.DW(15), .H_LEN(200), .V_LEN(150), .RD_LAT(1)) u_dut1 (
        .pclk(pclk), .rstn(rstn), .hen(hen), .ven(ven), .scale(scale), .mode(mode),
        .vram(vif1), .red(red1), .green(green1), .blue(blue1),
        .de_out(de1), .frame_start(fs1)
    );

    display_pipe #(.DW(15), .H_LEN(200), .V_LEN(150), .RD_LAT(3)) u_dut3 (
        .pclk(pclk), .rstn(rstn), .hen(hen), .ven(ven), .scale(scale), .mode(mode),
        .vram(vif3), .red(red3), .green(green3), .blue(blue3),
        .de_out(de3), .frame_start(fs3)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // VRAM models: each word holds the low 12 bits of its own address.
    logic [14:0] v1_q;
    logic [14:0] v3_q [3];
    always @(posedge pclk) begin
        v1_q    <= vif1.raddr;
        v3_q[0] <= vif3.raddr;
        v3_q[1] <= v3_q[0];
        v3_q[2] <= v3_q[1];
    end
    assign vif1.rdata = v1_q[11:0];
    assign vif3.rdata = v3_q[2][11:0];

    int cyc = 0;
    int vs, ls;
    int n_assert = 0, n_fail = 0;

    logic [11:0] lg_col1 [LOGN];
    logic [11:0] lg_col3 [LOGN];
    logic [14:0] lg_ra1  [LOGN];
    logic        lg_de1  [LOGN];
    logic        lg_de3  [LOGN];
    logic        lg_fs1  [LOGN];

    always @(negedge pclk) begin
        if (cyc < LOGN) begin
            lg_col1[cyc] <= {red1, green1, blue1};
            lg_col3[cyc] <= {red3, green3, blue3};
            lg_ra1[cyc]  <= vif1.raddr;
            lg_de1[cyc]  <= de1;
            lg_de3[cyc]  <= de3;
            lg_fs1[cyc]  <= fs1;
        end
    end

    function automatic logic [31:0] c1(input int i); return {20'd0, lg_col1[i]}; endfunction
    function automatic logic [31:0] c3(input int i); return {20'd0, lg_col3[i]}; endfunction
    function automatic logic [31:0] r1(input int i); return {17'd0, lg_ra1[i]};  endfunction
    function automatic logic [31:0] d1(input int i); return {31'd0, lg_de1[i]};  endfunction
    function automatic logic [31:0] d3(input int i); return {31'd0, lg_de3[i]};  endfunction
    function automatic logic [31:0] f1(input int i); return {31'd0, lg_fs1[i]};  endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
        cyc++;
    endtask

    task automatic vblank(input logic [1:0] sc);
        hen   = 1'b0;
        ven   = 1'b0;
        scale = sc;
        repeat (4) step();
        ven = 1'b1;
        vs  = cyc;
        step();
    endtask

    // One active line of act pixels; mode switches to sw_m at pixel sw_k.
    task automatic line(input int act, input int sw_k, input logic [1:0] sw_m);
        ls = cyc;
        for (int k = 0; k < act; k++) begin
            if (k == sw_k) mode = sw_m;
            hen = 1'b1;
            step();
        end
        hen = 1'b0;
        repeat (12) step();
    endtask

    int a0, a2, b0, b3, b4, d0, d1l, d2, d3l, dvs, e0, f0, nfs;
    int bar_x [12]   = '{0, 24, 25, 49, 50, 75, 100, 125, 150, 174, 175, 199};
    int bar_c [12]   = '{'hFFF, 'hFFF, 'hFF0, 'hFF0, 'h0FF, 'h0F0, 'hF0F, 'hF00,
                         'h00F, 'h00F, 'h000, 'h000};

    initial begin
        rstn = 1'b0; hen = 1'b1; ven = 1'b1; scale = 2'd2; mode = 2'd1;
        repeat (2) step();
        chk("rst_col1",   {20'd0, red1, green1, blue1}, 'h000);
        chk("rst_de1",    {31'd0, de1}, 'h0);
        chk("rst_fs1",    {31'd0, fs1}, 'h0);
        chk("rst_raddr1", {17'd0, vif1.raddr}, 'h0);
        chk("rst_col3",   {20'd0, red3, green3, blue3}, 'h000);
        hen = 1'b0; ven = 1'b0;
        repeat (2) step();
        rstn = 1'b1;
        step();

        // White, 4x: full 800-cycle lines of FFF, two cycles behind hen.
        mode = 2'd1;
        vblank(2'd2);
        line(800, -1, 2'd0); a0 = ls;
        line(800, -1, 2'd0);
        line(800, -1, 2'd0); a2 = ls;
        chk("fs_before",  f1(vs),      'h0);
        chk("fs_pulse",   f1(vs + 1),  'h1);
        chk("fs_after",   f1(vs + 2),  'h0);
        chk("w_col_pre",  c1(a0 + 1),  'h000);
        chk("w_col_first",c1(a0 + 2),  'hFFF);
        chk("w_de_pre",   d1(a0 + 1),  'h0);
        chk("w_de_first", d1(a0 + 2),  'h1);
        chk("w_col_last", c1(a0 + 801),'hFFF);
        chk("w_de_last",  d1(a0 + 801),'h1);
        chk("w_de_end",   d1(a0 + 802),'h0);
        chk("w_col_end",  c1(a0 + 802),'h000);
        chk("w_col_l2",   c1(a2 + 401),'hFFF);
        chk("w3_col_pre", c3(a0 + 3),  'h000);
        chk("w3_col_first",c3(a0 + 4), 'hFFF);
        chk("w3_de_last", d3(a0 + 803),'h1);
        chk("w3_de_end",  d3(a0 + 804),'h0);

        // VRAM, 4x: addresses step every 4 pixels and repeat over 4 lines.
        mode = 2'd0;
        vblank(2'd2);
        line(800, -1, 2'd0); b0 = ls;
        line(800, -1, 2'd0);
        line(800, -1, 2'd0);
        line(800, -1, 2'd0); b3 = ls;
        line(800, -1, 2'd0); b4 = ls;
        chk("v_ra_x0",    r1(b0),       'd0);
        chk("v_ra_x3",    r1(b0 + 3),   'd0);
        chk("v_ra_x4",    r1(b0 + 4),   'd1);
        chk("v_ra_x799",  r1(b0 + 799), 'd199);
        chk("v_col_x7",   c1(b0 + 9),   'h001);
        chk("v_col_x799", c1(b0 + 801), 'h0C7);
        chk("v_ra_l3",    r1(b3 + 4),   'd1);
        chk("v_ra_l4",    r1(b4 + 5),   'd201);
        chk("v_col_l4",   c1(b4 + 7),   'h0C9);
        chk("v_col_l4x600", c1(b4 + 602), 'h15E);
        chk("v3_col_l4",  c3(b4 + 9),   'h0C9);

        // Bars, checkerboard, mid-line mode switch, mid-frame scale change.
        mode = 2'd2;
        vblank(2'd0); dvs = vs;
        line(210, -1, 2'd0); d0 = ls;
        line(210, 0, 2'd3);  d1l = ls;
        mode = 2'd2;
        line(210, 30, 2'd1); d2 = ls;
        mode = 2'd0; scale = 2'd3;
        line(210, -1, 2'd0); d3l = ls;
        for (int i = 0; i < 12; i++)
            chk($sformatf("bar_x%0d", bar_x[i]), c1(d0 + bar_x[i] + 2), bar_c[i]);
        chk("bar3_x24",   c3(d0 + 28),  'hFFF);
        chk("bar3_x25",   c3(d0 + 29),  'hFF0);
        chk("bar3_de_pre",d3(d0 + 3),   'h0);
        chk("bar3_de",    d3(d0 + 4),   'h1);
        chk("chk_x0",     c1(d1l + 2),  'h000);
        chk("chk_x7",     c1(d1l + 9),  'h000);
        chk("chk_x8",     c1(d1l + 10), 'hFFF);
        chk("chk_x16",    c1(d1l + 18), 'h000);
        chk("chk_x24",    c1(d1l + 26), 'hFFF);
        chk("msw_x29",    c1(d2 + 31),  'hFF0);
        chk("msw_x30",    c1(d2 + 32),  'hFFF);
        chk("msw3_x29",   c3(d2 + 33),  'hFF0);
        chk("msw3_x30",   c3(d2 + 34),  'hFFF);
        chk("frozen_ra",  r1(d3l + 5),  'd605);
        chk("frozen_col", c1(d3l + 7),  'h25D);
        nfs = 0;
        for (int i = dvs; i < cyc; i++) if (lg_fs1[i] === 1'b1) nfs++;
        chk("fs_count",   32'(nfs),     'd1);

        // VRAM, 8x (scale picked up in the blanking): x saturates at 200.
        vblank(2'd3);
        line(1700, -1, 2'd0); e0 = ls;
        chk("sat_ra_x7",  r1(e0 + 7),    'd0);
        chk("sat_ra_x8",  r1(e0 + 8),    'd1);
        chk("sat_ra_1599",r1(e0 + 1599), 'd199);
        chk("sat_ra_1600",r1(e0 + 1600), 'd0);
        chk("sat_ra_1699",r1(e0 + 1699), 'd0);
        chk("sat_col_1599",c1(e0 + 1601),'h0C7);
        chk("sat_col_1600",c1(e0 + 1602),'h000);
        chk("sat_de_1600",d1(e0 + 1602), 'h1);
        chk("sat_de_1699",d1(e0 + 1701), 'h1);
        chk("sat_col_1699",c1(e0 + 1701),'h000);

        // Reset pulsed mid-line, then a clean frame.
        mode = 2'd0;
        vblank(2'd2);
        for (int k = 0; k < 100; k++) begin
            hen = 1'b1;
            step();
        end
        #3 rstn = 1'b0;
        #1;
        chk("mrst_col1",  {20'd0, red1, green1, blue1}, 'h000);
        chk("mrst_de1",   {31'd0, de1}, 'h0);
        chk("mrst_fs1",   {31'd0, fs1}, 'h0);
        chk("mrst_raddr1",{17'd0, vif1.raddr}, 'h0);
        chk("mrst_col3",  {20'd0, red3, green3, blue3}, 'h000);
        chk("mrst_de3",   {31'd0, de3}, 'h0);
        step();
        step();
        rstn = 1'b1;
        repeat (200) step();
        hen = 1'b0;
        repeat (12) step();
        vblank(2'd2);
        line(800, -1, 2'd0); f0 = ls;
        line(800, -1, 2'd0);
        chk("post_de",    d1(f0 + 2),   'h1);
        chk("post_ra_x4", r1(f0 + 4),   'd1);
        chk("post_col_x4",c1(f0 + 6),   'h001);
        chk("post_col_x799", c1(f0 + 801), 'h0C7);
        chk("post3_col_x799", c3(f0 + 803), 'h0C7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/display_pipe.md
DISPLAY_PIPE -- requirements
Module: display_pipe

Interface
REQ-001 Parameter DW, default 15, VRAM address width.
REQ-002 Parameter H_LEN, default 200, source image width in pixels.
REQ-003 Parameter V_LEN, default 150, source image height in lines.
REQ-004 Parameter RD_LAT, default 1, VRAM read latency in cycles; legal range 1..3.
REQ-005 pclk  input  1  pixel clock; all state on its rising edge.
REQ-006 rstn  input  1  asynchronous, active-low reset.
REQ-007 hen  input  1  horizontal active-video enable.
REQ-008 ven  input  1  vertical active-video enable.
REQ-009 scale  input  2  upscale select: 0=x1, 1=x2, 2=x4, 3=x8.
REQ-010 mode  input  2  source select: 0=VRAM, 1=white, 2=colour bars, 3=checkerboard.
REQ-011 rdata  input  12  VRAM RGB444 data, valid RD_LAT cycles after raddr.
REQ-012 raddr  output  DW  VRAM read address.
REQ-013 red, green, blue  output  4 each  registered pixel colour.
REQ-014 de_out  output  1  registered data-enable, aligned with the colour outputs.
REQ-015 frame_start  output  1  one-cycle pulse marking the start of a frame.

Function
REQ-016 The block SHALL hold an internal scale_r that follows scale while ven=0 and is frozen while ven=1; F=2^scale_r.
REQ-017 While hen=0, the horizontal sub-counter x_sub and the source column x_idx SHALL be 0.
REQ-018 On each hen=1 cycle, x_sub SHALL increment; when x_sub=F-1 it SHALL wrap to 0 and x_idx SHALL increment, saturating at H_LEN.
REQ-019 While ven=0, y_sub, y_idx and line_base SHALL be 0.
REQ-020 On a hen falling edge (hen was 1 on the previous cycle, now 0) with ven=1, y_sub SHALL increment; at y_sub=F-1 it SHALL wrap to 0, y_idx SHALL increment (saturating at V_LEN), and line_base SHALL increase by H_LEN.
REQ-021 Address generation SHALL use only adders and comparators, with no multiplier: raddr = line_base + x_idx, combinational from registered state.
REQ-022 The pixel is in-bounds iff x_idx<H_LEN and y_idx<V_LEN; when out-of-bounds, raddr SHALL be 0.
REQ-023 Active = hen & ven & in-bounds; {active, mode, x_idx, y_idx} SHALL be delayed RD_LAT cycles to align with rdata.
REQ-024 Colour sources:
- mode 0: rdata.
- mode 1: 12'hFFF.
- mode 2: eight equal bars selected by comparing x_idx against localparam thresholds H_LEN*k/8, colours in order FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
- mode 3: FFF when x_idx[3]^y_idx[3] is 1, else 000.
REQ-025 {red, green, blue} SHALL be registered: the selected colour when the delayed active is 1, else 12'h000; total latency from a hen=1 cycle to its colour SHALL be RD_LAT+1 cycles.
REQ-026 de_out SHALL equal hen&ven delayed RD_LAT+1 cycles, independent of bounds.
REQ-027 frame_start SHALL be 1 for exactly the one cycle after ven rises from 0 to 1.
REQ-028 A change of mode SHALL take effect per pixel with the same RD_LAT+1 latency as that pixel's data.

Reset
REQ-029 When rstn=0, all counters, line_base, scale_r, delay stages, colour outputs, de_out and frame_start SHALL be 0, and raddr SHALL be 0.
REQ-030 Reset deassertion mid-frame SHALL resume with counters at 0; correct alignment SHALL be reached at the next ven rising edge.

Structure
REQ-031 The shared package ddp_pkg SHALL hold the mode encodings, the scale encodings and the 8-entry bar colour table.
REQ-032 The parametrised delay line (width, depth) SHALL be the sub-module ddp_delay, instantiated for the active/mode/index pipeline and for de_out.

Verification
REQ-033 The bench SHALL cover: mode=1, scale=2, 800x600 timing -> de_out asserted 600 lines x 800 cycles, colour FFF within the 4x-scaled 800x600 region, RD_LAT+1 cycles after hen.
REQ-034 The bench SHALL cover: mode=0, scale=2, VRAM holding addr[11:0] -> screen pixel (x,y) shows (y/4)*200+(x/4); raddr steps every 4 cycles and repeats over 4 lines.
REQ-035 The bench SHALL cover: mode=0, scale=3, H_LEN=200 -> x_idx saturates at 200 after 1600 cycles; colour is 000 beyond x_idx 200 and raddr=0.
REQ-036 The bench SHALL cover: mode=2, scale=0, H_LEN=200 -> bar boundaries at x = 25, 50, ..., 175, with colours matching the table.
REQ-037 The bench SHALL cover: RD_LAT=3, and scale changed mid-frame -> latency of 4 cycles, and the new scale is applied only after the next ven=0 period; frame_start pulses once per frame.
REQ-038 The bench SHALL cover: rstn pulsed low mid-line -> all outputs are 0 within the reset cycle, and the next frame's output is correct.
